// File: rtl/byte_store_arbiter.sv
// Two-client valid/ready arbiter sequencing reads/writes onto a single-byte store.
// Define BYTE_STORE_ARB_RR_EN for round-robin grant; otherwise req0 has fixed priority.
module byte_store_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_rerr,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_rerr,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_output_enable
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_t;

    localparam logic [7:0] TMO = 8'(RD_TIMEOUT);

    state_t                state;
    state_t                state_nx;
    logic [7:0]            cnt;
    logic [7:0]            cnt_nx;
    logic                  win;
    logic                  win_nx;
    logic [1:0]            rdy_nx;
    logic [1:0]            rv_nx;
    logic [1:0]            rerr_nx;
    logic [DATA_WIDTH-1:0] rd0_nx;
    logic [DATA_WIDTH-1:0] rd1_nx;
    logic [DATA_WIDTH-1:0] din_nx;
    logic                  we_nx;
    logic                  re_nx;
    logic                  any_req;
    logic                  pick;

    assign any_req = req0_valid | req1_valid;

`ifdef BYTE_STORE_ARB_RR_EN
    logic last_q;

    // On contention, the client that did not win last time goes first
    assign pick = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_q <= pick;
        end
    end
`else
    assign pick = ~req0_valid;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        win_nx   = win;
        rdy_nx   = 2'b00;
        rv_nx    = 2'b00;
        rerr_nx  = 2'b00;
        rd0_nx   = req0_rdata;
        rd1_nx   = req1_rdata;
        din_nx   = mem_data_in;
        we_nx    = 1'b0;
        re_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    win_nx = pick;
                    rdy_nx = pick ? 2'b10 : 2'b01;
                    if (pick ? req1_write : req0_write) begin
                        state_nx = WR;
                        we_nx    = 1'b1;
                        din_nx   = pick ? req1_wdata : req0_wdata;
                    end else begin
                        state_nx = RD;
                        re_nx    = 1'b1;
                        cnt_nx   = '0;
                    end
                end
            end
            WR: begin
                state_nx = IDLE;
            end
            RD: begin
                // Returned data takes precedence over a coincident timeout
                if (mem_output_enable) begin
                    state_nx = IDLE;
                    rv_nx    = win ? 2'b10 : 2'b01;
                    if (win) begin
                        rd1_nx = mem_data_out;
                    end else begin
                        rd0_nx = mem_data_out;
                    end
                end else if (cnt + 8'd1 == TMO) begin
                    state_nx = IDLE;
                    rv_nx    = win ? 2'b10 : 2'b01;
                    rerr_nx  = win ? 2'b10 : 2'b01;
                    if (win) begin
                        rd1_nx = '0;
                    end else begin
                        rd0_nx = '0;
                    end
                end else begin
                    cnt_nx = cnt + 8'd1;
                    re_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            win              <= 1'b0;
            req0_ready       <= 1'b0;
            req1_ready       <= 1'b0;
            req0_rvalid      <= 1'b0;
            req1_rvalid      <= 1'b0;
            req0_rerr        <= 1'b0;
            req1_rerr        <= 1'b0;
            req0_rdata       <= '0;
            req1_rdata       <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_data_in      <= '0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            win              <= win_nx;
            req0_ready       <= rdy_nx[0];
            req1_ready       <= rdy_nx[1];
            req0_rvalid      <= rv_nx[0];
            req1_rvalid      <= rv_nx[1];
            req0_rerr        <= rerr_nx[0];
            req1_rerr        <= rerr_nx[1];
            req0_rdata       <= rd0_nx;
            req1_rdata       <= rd1_nx;
            mem_read_enable  <= re_nx;
            mem_write_enable <= we_nx;
            mem_data_in      <= din_nx;
        end
    end

endmodule
